// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Moore-style main control FSM for the multicycle CPU datapath. Sequences
//   fetch / decode / execute / memory / writeback over a shared ALU, unified
//   memory and register file, one FSM step per clock.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   opcode_i [OPW]         instruction[31:26] from the IR (valid from DECODE)
//   zero_i                 ALU zero flag (qualifies beq/bne in BRANCH)
//   pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o   enables
//   i_or_d_o, reg_dst_o, mem_to_reg_o, alu_src_a_o                  1-bit selects
//   alu_src_b_o, alu_op_o, pc_source_o                               2-bit selects
//   ext_op_o               extender mode: 1 = sign, 0 = zero
//   op_q_o [OPW]           opcode latched at the end of DECODE
//   state_o [4]            current state encoding
//   illegal_o              one-cycle pulse after an unsupported opcode is decoded
//   retired_o [CNTW]       completed-instruction count (wraps)
module multicycle_ctrl #(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [OPW-1:0]  opcode_i,
    input  logic            zero_i,
    output logic            pc_write_o,
    output logic            ir_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            i_or_d_o,
    output logic            reg_write_o,
    output logic            reg_dst_o,
    output logic            mem_to_reg_o,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [1:0]      alu_op_o,
    output logic [1:0]      pc_source_o,
    output logic            ext_op_o,
    output logic [OPW-1:0]  op_q_o,
    output logic [3:0]      state_o,
    output logic            illegal_o,
    output logic [CNTW-1:0] retired_o
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] R_EXEC    = 4'd6;
    localparam logic [3:0] R_WB      = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] JUMP      = 4'd9;
    localparam logic [3:0] I_EXEC    = 4'd10;
    localparam logic [3:0] I_WB      = 4'd11;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);

    logic [3:0]      state;
    logic [3:0]      state_nx;
    logic [OPW-1:0]  op_q;
    logic [CNTW-1:0] retired;
    logic            illegal_q;
    logic            decode_legal;
    logic            retire;

    // Dispatch uses the live opcode, since op_q only updates at the end of DECODE.
    always_comb begin
        decode_legal = 1'b1;
        state_nx     = FETCH;
        case (state)
            FETCH:    state_nx = DECODE;
            DECODE: begin
                case (opcode_i)
                    OP_RTYPE:                          state_nx = R_EXEC;
                    OP_LW, OP_SW:                      state_nx = MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_nx = BRANCH;
                    OP_J:                              state_nx = JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_nx = I_EXEC;
                    default: begin
                        state_nx     = FETCH;
                        decode_legal = 1'b0;
                    end
                endcase
            end
            MEM_ADDR: state_nx = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: state_nx = MEM_WB;
            R_EXEC:   state_nx = R_WB;
            I_EXEC:   state_nx = I_WB;
            default:  state_nx = FETCH;
        endcase
    end

    always_comb begin
        case (state)
            MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP: retire = 1'b1;
            default:                                     retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FETCH;
            op_q      <= '0;
            retired   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            illegal_q <= (state == DECODE) && !decode_legal;
            if (state == DECODE) begin
                op_q <= opcode_i;
            end
            if (retire) begin
                retired <= retired + CNTW'(1);
            end
        end
    end

    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        i_or_d_o     = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        pc_source_o  = 2'b00;
        ext_op_o     = 1'b1;
        case (state)
            FETCH: begin
                mem_read_o  = 1'b1;
                ir_write_o  = 1'b1;
                pc_write_o  = 1'b1;
                alu_src_b_o = 2'b01;
            end
            DECODE: begin
                alu_src_b_o = 2'b11;
                ext_op_o    = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b01;
                pc_source_o = 2'b01;
                // Only Mealy output: branch outcome qualified by the live zero flag.
                pc_write_o  = ((op_q == OP_BEQ) && zero_i) || ((op_q == OP_BNE) && !zero_i);
            end
            JUMP: begin
                pc_source_o = 2'b10;
                pc_write_o  = 1'b1;
            end
            I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = 2'b11;
                ext_op_o    = !((op_q == OP_ANDI) || (op_q == OP_ORI));
            end
            I_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b0;
            end
            default: ;
        endcase
    end

    assign op_q_o    = op_q;
    assign state_o   = state;
    assign illegal_o = illegal_q;
    assign retired_o = retired;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style main control FSM for the multicycle variant of the CPU datapath.
- Sequences fetch / decode / execute / memory / writeback over a shared ALU, unified memory and register file.
- Drives the extend-mode select of the immediate sign/zero extender, plus all mux selects and write enables.
- Sits between the instruction register (opcode source) and the datapath; one FSM step per clock.

Parameters:
- OPW, 6, opcode width.
- CNTW, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset. Synchronous, active-high.
- opcode_i  in  OPW  instruction[31:26] from the IR; valid from DECODE onward.
- zero_i  in  1  ALU zero flag.
- pc_write_o  out  1  PC load enable (includes the qualified branch condition).
- ir_write_o  out  1  IR load enable.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_write_o  out  1  register-file write enable.
- reg_dst_o  out  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU B select: 00 = rt, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- alu_op_o  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct, 11 = opcode.
- pc_source_o  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ext_op_o  out  1  extender mode: 1 = sign-extend, 0 = zero-extend.
- op_q_o  out  OPW  latched opcode, for the ALU control decoder.
- state_o  out  4  current state encoding.
- illegal_o  out  1  one-cycle pulse when an unsupported opcode is decoded.
- retired_o  out  CNTW  count of completed instructions.

Behaviour:
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5.
  - R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11.
  - Encodings 12–15 are unreachable and go to FETCH.
- Reset (rst_i high at a clock edge):
  - state = FETCH, op_q = 0, retired = 0, illegal = 0.
  - Reset overrides any in-flight instruction; no partial writeback is completed.
  - Outputs after reset equal the FETCH decode.
- Output defaults: all enables 0, all selects 0, ext_op_o = 1. Each state overrides only the fields listed.
  - FETCH: mem_read = 1, ir_write = 1, pc_write = 1, src_b = 01.
  - DECODE: src_b = 11, ext_op = 1. op_q <= opcode_i at the end of this cycle.
  - MEM_ADDR: src_a = 1, src_b = 10.
  - MEM_READ: mem_read = 1, i_or_d = 1.
  - MEM_WB: reg_write = 1, mem_to_reg = 1.
  - MEM_WRITE: mem_write = 1, i_or_d = 1.
  - R_EXEC: src_a = 1, alu_op = 10.
  - R_WB: reg_write = 1, reg_dst = 1.
  - BRANCH: src_a = 1, alu_op = 01, pc_source = 01.
    - pc_write = (op_q == beq & zero_i) | (op_q == bne & ~zero_i). This is the only Mealy output.
  - JUMP: pc_source = 10, pc_write = 1.
  - I_EXEC: src_a = 1, src_b = 10, alu_op = 11. ext_op = 0 for andi/ori, 1 otherwise.
  - I_WB: reg_write = 1, reg_dst = 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on opcode_i (live, not op_q):
    - 000000 -> R_EXEC.
    - 100011 (lw) / 101011 (sw) -> MEM_ADDR.
    - 000100 (beq) / 000101 (bne) -> BRANCH.
    - 000010 (j) -> JUMP.
    - 001000 addi / 001010 slti / 001100 andi / 001101 ori -> I_EXEC.
    - Any other opcode -> FETCH with illegal_o = 1 for one cycle.
  - MEM_ADDR -> MEM_READ if op_q == lw, else MEM_WRITE.
  - MEM_READ -> MEM_WB.
  - R_EXEC -> R_WB.
  - I_EXEC -> I_WB.
  - MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP -> FETCH.
- Latencies, in cycles including FETCH: lw 5, sw 4, R 4, I 4, beq/bne 3, j 3.
- retired_o increments on the edge leaving MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH or JUMP.
  - Illegal opcodes do not increment it.
  - Wraps modulo 2^CNTW.
- Branch taken or not taken costs the same 3 cycles; only pc_write differs.

Test Plan:
- Reset: hold rst_i for 2 cycles -> state_o = 0, retired_o = 0, mem_read = ir_write = pc_write = 1, src_b = 01.
- lw (opcode 100011) -> states 0,1,2,3,4,0. mem_read = 1 with i_or_d = 1 in state 3. reg_write = 1 with mem_to_reg = 1 in state 4. retired_o = 1.
- beq with zero_i = 1, then beq with zero_i = 0 -> pc_write_o = 1, then 0, in state 8, pc_source = 01 both times. retired_o advances by 2. Repeat with bne: pc_write is inverted.
- andi (001100) -> ext_op_o = 0 in I_EXEC. addi (001000) -> ext_op_o = 1. Both end with reg_write = 1, reg_dst = 0 in state 11.
- Opcode 111111 -> DECODE returns to FETCH with a single-cycle illegal_o = 1. retired_o unchanged.
- Assert rst_i during MEM_READ of an lw -> next state FETCH. No reg_write pulse occurs. retired_o = 0.
